cycle_sequencer: RTL and testbench
==================================

Name: cycle_sequencer

Overview:
- Timing and opcode-latch stage directly upstream of the control-unit X-group decoders (X0..X3).
- Generates the one-hot T-state step (4 bits) and the one-hot M-cycle count (8 bits).
- Latches the opcode from the data bus at fetch and drives the one-hot x/y/z fields and the CB-prefix flag that the X-group decoders consume as i_Active, i_Z and related inputs.

Parameters:
- COUNT_WIDTH, 8, width of the one-hot M-cycle count; the count wraps after bit COUNT_WIDTH-1.
- RESET_OPCODE, 8'h00, IR value after reset. NOP, so the first enabled M-cycle performs a fetch.

Ports:
- i_Clk  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Clk_Enable  input  1  CPU T-state enable; state advances only on enabled clocks.
- i_Stall  input  1  memory wait; freezes step and count while high.
- i_IR_Fetch  input  1  OR of every X-group o_IR_Fetch; marks the current M-cycle as the last of the instruction.
- i_Data_Bus  input  8  opcode byte from the bus, sampled at the fetch point.
- o_Cycle_Step  output  4  one-hot T-state.
- o_Cycle_Count  output  COUNT_WIDTH  one-hot M-cycle index within the instruction.
- o_IR  output  8  latched opcode.
- o_X  output  4  one-hot IR[7:6]; each bit is the i_Active of X0..X3.
- o_Y  output  8  one-hot IR[5:3].
- o_Z  output  8  one-hot IR[2:0].
- o_CB_Mode  output  1  the current IR is the second byte of a CB-prefixed instruction.
- o_Seq_Fault  output  1  one-cycle pulse when the count wraps without a fetch.

Behaviour:
- Reset (sync, highest priority; overrides i_Clk_Enable and i_Stall):
  - step=0001, count=...0001, IR=RESET_OPCODE, o_CB_Mode=0, o_Seq_Fault=0.
- Reset mid-instruction discards all progress. No partial IR update.
- Advance condition: adv = i_Clk_Enable & ~i_Stall. When adv=0, step, count, IR and CB hold.
- Step: rotates left on every adv clock: 0001->0010->0100->1000->0001.
- M-cycle boundary: an adv clock with step=1000.
  - If i_IR_Fetch=1 (sampled on that clock):
    - IR <= i_Data_Bus.
    - count <= ...0001.
    - o_CB_Mode <= (old IR==8'hCB) & ~o_CB_Mode. So CB,CB decodes the second byte as CB-page opcode 0xCB, never a double prefix.
  - Else if count bit COUNT_WIDTH-1 is set:
    - count <= ...0001; IR unchanged.
    - o_Seq_Fault=1 for exactly one clock.
  - Else count <= count<<1.
- i_IR_Fetch is ignored on non-boundary clocks.
- Decode of o_X/o_Y/o_Z:
  - Combinational from the IR register; zero latency after an IR update.
  - Always exactly one bit set in each.
  - No gating by o_CB_Mode; downstream CB decoders qualify with o_CB_Mode.
- Latency: an opcode on i_Data_Bus at the fetch boundary is visible on o_IR/o_X/o_Y/o_Z on the next clock, together with step=0001 and count=...0001.
- Simultaneous events:
  - Reset beats everything.
  - i_Stall beats i_Clk_Enable.
  - Fetch beats wrap: a fetch at count bit COUNT_WIDTH-1 raises no fault.
- Invariant: o_Cycle_Step and o_Cycle_Count are always one-hot, including after stall and reset. An assertion in the bench checks this.

Decomposition:
- Shared package (control-unit-wide), consumed by the X0..X3 decoders and this block:
  - Step one-hot constants: T1..T4 = 4'b0001..4'b1000.
  - M-cycle constants: M1..M8.
  - OPCODE_NOP=8'h00 and OPCODE_CB_PREFIX=8'hCB.
  - Field slice positions: X=[7:6], Y=[5:3], Z=[2:0].
- One natural sub-module: onehot_decode (N-bit binary to 2^N one-hot), instantiated three times for x, y and z.

Test Plan:
- Reset, then 8 enabled clocks, i_IR_Fetch=1 at each boundary, bus=8'h80 -> step sequence 1,2,4,8,1...; IR=8'h80 on clock 5; o_X=0100, o_Z=00000001, count=0001.
- Two-M-cycle instruction with IR=8'h86: fetch held low at the first boundary, high at the second -> count 01 then 10, then back to 01 with new IR; no fault.
- Assert i_Stall for 3 clocks at step=0100, count=0010 -> both outputs frozen; resume from step 1000; i_Clk_Enable=0 behaves identically.
- Fetch 8'hCB, then fetch 8'h37 -> o_CB_Mode=1 with IR=8'h37, o_Y=01000000, o_Z=10000000. The next fetch clears o_CB_Mode. A CB,CB sequence gives o_CB_Mode=1 with IR=8'hCB.
- Never assert fetch for 8 M-cycles -> count wraps to ...0001 with a one-clock o_Seq_Fault pulse; IR unchanged.
- Assert i_Reset at step=0100, count=0100, with i_Stall=1 and fetch=1 -> next clock: step=0001, count=0001, IR=8'h00, o_X=0001, o_CB_Mode=0.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared control-unit definitions used by the cycle sequencer and the X0..X3
// decoders. These include the T-state and M-cycle one-hot codes, the special
// opcodes and the x/y/z field slice positions.
package cycle_sequencer_pkg;

  // One-hot T-state codes; T4 is the last step of every M-cycle.
  typedef enum logic [3:0] {
    T1 = 4'b0001,
    T2 = 4'b0010,
    T3 = 4'b0100,
    T4 = 4'b1000
  } step_e;

  // One-hot M-cycle codes for the default eight-cycle count.
  localparam logic [7:0] M1 = 8'b0000_0001;
  localparam logic [7:0] M2 = 8'b0000_0010;
  localparam logic [7:0] M3 = 8'b0000_0100;
  localparam logic [7:0] M4 = 8'b0000_1000;
  localparam logic [7:0] M5 = 8'b0001_0000;
  localparam logic [7:0] M6 = 8'b0010_0000;
  localparam logic [7:0] M7 = 8'b0100_0000;
  localparam logic [7:0] M8 = 8'b1000_0000;

  localparam logic [7:0] OPCODE_NOP       = 8'h00;
  localparam logic [7:0] OPCODE_CB_PREFIX = 8'hCB;

  // Opcode field positions: x = IR[7:6], y = IR[5:3], z = IR[2:0].
  localparam int X_MSB = 7;
  localparam int X_LSB = 6;
  localparam int Y_MSB = 5;
  localparam int Y_LSB = 3;
  localparam int Z_MSB = 2;
  localparam int Z_LSB = 0;

endpackage

// File: rtl/cycle_sequencer_onehot_decode.sv
// Decodes an N-bit binary field to a 2^N-bit one-hot vector.
// Exactly one output bit is always set.
module onehot_decode #(
  parameter int N = 2
) (
  input  logic [N-1:0]      bin_i,
  output logic [2**N-1:0]   onehot_o
);

  // Set exactly the bit indexed by the binary input.
  always_comb begin
    onehot_o        = '0;
    onehot_o[bin_i] = 1'b1;
  end

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer and opcode latch that feeds the X-group decoders.
// The step rotates through T1..T4 on every enabled, unstalled clock.
// At the end of T4 the M-cycle either fetches a new opcode or moves on to the
// next M-cycle. If it would move past the last M-cycle, it wraps instead and
// flags a sequencing fault.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int         COUNT_WIDTH  = 8,
  parameter logic [7:0] RESET_OPCODE = OPCODE_NOP
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Clk_Enable,
  input  logic                   i_Stall,
  input  logic                   i_IR_Fetch,
  input  logic [7:0]             i_Data_Bus,
  output logic [3:0]             o_Cycle_Step,
  output logic [COUNT_WIDTH-1:0] o_Cycle_Count,
  output logic [7:0]             o_IR,
  output logic [3:0]             o_X,
  output logic [7:0]             o_Y,
  output logic [7:0]             o_Z,
  output logic                   o_CB_Mode,
  output logic                   o_Seq_Fault
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_FIRST = COUNT_WIDTH'(1);

  step_e                   step_q, step_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [7:0]              ir_q, ir_d;
  logic                    cb_q, cb_d;
  logic                    fault_q, fault_d;
  logic                    adv;

  assign adv = i_Clk_Enable & ~i_Stall;

  // Next-state logic. Nothing moves unless adv is high. When the step is T4,
  // this clock is the M-cycle boundary: a fetch takes priority over a wrap.
  always_comb begin
    step_d  = step_q;
    count_d = count_q;
    ir_d    = ir_q;
    cb_d    = cb_q;
    fault_d = 1'b0;
    if (adv) begin
      step_d = step_e'({step_q[2:0], step_q[3]});
      if (step_q == T4) begin
        if (i_IR_Fetch) begin
          ir_d    = i_Data_Bus;
          count_d = COUNT_FIRST;
          cb_d    = (ir_q == OPCODE_CB_PREFIX) & ~cb_q;
        end else if (count_q[COUNT_WIDTH-1]) begin
          count_d = COUNT_FIRST;
          fault_d = 1'b1;
        end else begin
          count_d = count_q << 1;
        end
      end
    end
  end

  // State registers. Reset wins over enable and stall and discards any
  // partially completed instruction.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      step_q  <= T1;
      count_q <= COUNT_FIRST;
      ir_q    <= RESET_OPCODE;
      cb_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      count_q <= count_d;
      ir_q    <= ir_d;
      cb_q    <= cb_d;
      fault_q <= fault_d;
    end
  end

  assign o_Cycle_Step  = step_q;
  assign o_Cycle_Count = count_q;
  assign o_IR          = ir_q;
  assign o_CB_Mode     = cb_q;
  assign o_Seq_Fault   = fault_q;

  onehot_decode #(.N(2)) u_decode_x (
    .bin_i    (ir_q[X_MSB:X_LSB]),
    .onehot_o (o_X)
  );

  onehot_decode #(.N(3)) u_decode_y (
    .bin_i    (ir_q[Y_MSB:Y_LSB]),
    .onehot_o (o_Y)
  );

  onehot_decode #(.N(3)) u_decode_z (
    .bin_i    (ir_q[Z_MSB:Z_LSB]),
    .onehot_o (o_Z)
  );

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer.
// The driver keeps an index-based model and queues the expected state after
// each clock. A monitor pops and compares that state just after every edge.
// Hand-computed spot checks cover the key scenarios.
module tb_cycle_sequencer;

  logic       clk;
  logic       rst;
  logic       clkEn;
  logic       stall;
  logic       irFetch;
  logic [7:0] dataBus;
  logic [3:0] cycleStep;
  logic [7:0] cycleCount;
  logic [7:0] ir;
  logic [3:0] xField;
  logic [7:0] yField;
  logic [7:0] zField;
  logic       cbMode;
  logic       seqFault;

  typedef struct packed {
    logic [3:0] step;
    logic [7:0] count;
    logic [7:0] ir;
    logic [3:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       cb;
    logic       fault;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  int         mStep;
  int         mCount;
  logic [7:0] mIr;
  logic       mCb;
  logic       mFault;

  cycle_sequencer #(.COUNT_WIDTH(8), .RESET_OPCODE(8'h00)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Clk_Enable  (clkEn),
    .i_Stall       (stall),
    .i_IR_Fetch    (irFetch),
    .i_Data_Bus    (dataBus),
    .o_Cycle_Step  (cycleStep),
    .o_Cycle_Count (cycleCount),
    .o_IR          (ir),
    .o_X           (xField),
    .o_Y           (yField),
    .o_Z           (zField),
    .o_CB_Mode     (cbMode),
    .o_Seq_Fault   (seqFault)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value against its required value and count the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one clock of inputs, advance the model, and queue the expected state.
  task automatic applyStimulus(input logic r, input logic en, input logic st,
                               input logic fe, input logic [7:0] bus);
    exp_t e;
    rst = r; clkEn = en; stall = st; irFetch = fe; dataBus = bus;
    if (r) begin
      mStep = 0; mCount = 0; mIr = 8'h00; mCb = 1'b0; mFault = 1'b0;
    end else begin
      mFault = 1'b0;
      if (en && !st) begin
        if (mStep == 3) begin
          if (fe) begin
            mCb    = (mIr == 8'hCB) && !mCb;
            mIr    = bus;
            mCount = 0;
          end else if (mCount == 7) begin
            mCount = 0;
            mFault = 1'b1;
          end else begin
            mCount = mCount + 1;
          end
        end
        mStep = (mStep + 1) % 4;
      end
    end
    e.step  = 4'(1 << mStep);
    e.count = 8'(1 << mCount);
    e.ir    = mIr;
    e.x     = 4'(1 << mIr[7:6]);
    e.y     = 8'(1 << mIr[5:3]);
    e.z     = 8'(1 << mIr[2:0]);
    e.cb    = mCb;
    e.fault = mFault;
    expQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runCycles(input int n, input logic en, input logic st,
                           input logic fe, input logic [7:0] bus);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, en, st, fe, bus);
  endtask

  // Monitor: the one-hot invariant, then a scoreboard compare just after each edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      checks++;
      assert ($onehot(cycleStep) && $onehot(cycleCount))
      else begin
        failures++;
        $display("[TB] FAIL onehot step=%b count=%b", cycleStep, cycleCount);
      end
    end
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("sb step",  32'(cycleStep),  32'(monExp.step));
      checkOutput("sb count", 32'(cycleCount), 32'(monExp.count));
      checkOutput("sb ir",    32'(ir),         32'(monExp.ir));
      checkOutput("sb x",     32'(xField),     32'(monExp.x));
      checkOutput("sb y",     32'(yField),     32'(monExp.y));
      checkOutput("sb z",     32'(zField),     32'(monExp.z));
      checkOutput("sb cb",    32'(cbMode),     32'(monExp.cb));
      checkOutput("sb fault", 32'(seqFault),   32'(monExp.fault));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed scenarios with hand-computed spot checks.
  initial begin
    rst = 1'b1; clkEn = 1'b0; stall = 1'b0; irFetch = 1'b0; dataBus = 8'h00;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    started = 1;
    checkOutput("reset step",  32'(cycleStep),  32'h1);
    checkOutput("reset count", 32'(cycleCount), 32'h01);
    checkOutput("reset ir",    32'(ir),         32'h00);
    checkOutput("reset x",     32'(xField),     32'h1);
    checkOutput("reset cb",    32'(cbMode),     32'h0);
    checkOutput("reset fault", 32'(seqFault),   32'h0);

    // Single-M-cycle instructions of 0x80.
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'h80);
    checkOutput("fetch80 ir",    32'(ir),         32'h80);
    checkOutput("fetch80 x",     32'(xField),     32'h4);
    checkOutput("fetch80 z",     32'(zField),     32'h01);
    checkOutput("fetch80 count", 32'(cycleCount), 32'h01);
    checkOutput("fetch80 step",  32'(cycleStep),  32'h1);
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'h80);
    checkOutput("second80 step", 32'(cycleStep),  32'h1);

    // Two-M-cycle 0x86; fetch high on non-boundary clocks must be ignored.
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'h86);
    checkOutput("fetch86 ir",    32'(ir),         32'h86);
    runCycles(3, 1'b1, 1'b0, 1'b1, 8'h55);
    runCycles(1, 1'b1, 1'b0, 1'b0, 8'h55);
    checkOutput("m2 count",      32'(cycleCount), 32'h02);
    checkOutput("m2 ir held",    32'(ir),         32'h86);
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("m2 end count",  32'(cycleCount), 32'h01);
    checkOutput("m2 end fault",  32'(seqFault),   32'h0);

    // Stall and clock-enable freeze at step 0100 / count 0010.
    runCycles(6, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("prestall step",  32'(cycleStep),  32'h4);
    checkOutput("prestall count", 32'(cycleCount), 32'h02);
    runCycles(3, 1'b1, 1'b1, 1'b1, 8'h00);
    checkOutput("stall step",     32'(cycleStep),  32'h4);
    checkOutput("stall count",    32'(cycleCount), 32'h02);
    runCycles(3, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("noen step",      32'(cycleStep),  32'h4);
    checkOutput("noen count",     32'(cycleCount), 32'h02);
    runCycles(1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("resume step",    32'(cycleStep),  32'h8);

    // CB prefix handling.
    runCycles(1, 1'b1, 1'b0, 1'b1, 8'hCB);
    checkOutput("cb1 ir",  32'(ir),     32'hCB);
    checkOutput("cb1 cb",  32'(cbMode), 32'h0);
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'h37);
    checkOutput("cb37 cb", 32'(cbMode), 32'h1);
    checkOutput("cb37 ir", 32'(ir),     32'h37);
    checkOutput("cb37 x",  32'(xField), 32'h1);
    checkOutput("cb37 y",  32'(yField), 32'h40);
    checkOutput("cb37 z",  32'(zField), 32'h80);
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'hCB);
    checkOutput("cbclr cb", 32'(cbMode), 32'h0);
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'hCB);
    checkOutput("cbcb cb",  32'(cbMode), 32'h1);
    checkOutput("cbcb ir",  32'(ir),     32'hCB);
    runCycles(4, 1'b1, 1'b0, 1'b1, 8'hCB);
    checkOutput("cbcbcb cb", 32'(cbMode), 32'h0);

    // Count wrap without fetch.
    runCycles(31, 1'b1, 1'b0, 1'b0, 8'hFF);
    checkOutput("prewrap count", 32'(cycleCount), 32'h80);
    checkOutput("prewrap step",  32'(cycleStep),  32'h8);
    runCycles(1, 1'b1, 1'b0, 1'b0, 8'hFF);
    checkOutput("wrap count", 32'(cycleCount), 32'h01);
    checkOutput("wrap fault", 32'(seqFault),   32'h1);
    checkOutput("wrap ir",    32'(ir),         32'hCB);
    runCycles(1, 1'b1, 1'b0, 1'b0, 8'hFF);
    checkOutput("wrap pulse end", 32'(seqFault), 32'h0);

    // Fetch on the last M-cycle beats the wrap.
    runCycles(30, 1'b1, 1'b0, 1'b0, 8'hFF);
    checkOutput("lastm count", 32'(cycleCount), 32'h80);
    runCycles(1, 1'b1, 1'b0, 1'b1, 8'h12);
    checkOutput("fetchwrap fault", 32'(seqFault),   32'h0);
    checkOutput("fetchwrap count", 32'(cycleCount), 32'h01);
    checkOutput("fetchwrap ir",    32'(ir),         32'h12);

    // Mid-instruction reset with stall and fetch also asserted.
    runCycles(10, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("prerst step",  32'(cycleStep),  32'h4);
    checkOutput("prerst count", 32'(cycleCount), 32'h04);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
    checkOutput("midrst step",  32'(cycleStep),  32'h1);
    checkOutput("midrst count", 32'(cycleCount), 32'h01);
    checkOutput("midrst ir",    32'(ir),         32'h00);
    checkOutput("midrst x",     32'(xField),     32'h1);
    checkOutput("midrst cb",    32'(cbMode),     32'h0);

    runCycles(2, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
